// File: rtl/img_pkg.sv
// Shared image geometry, pixel/coordinate types and scan state encoding
// for the padded-frame writer.
package img_pkg;

  localparam int unsigned IMG_W = 64;
  localparam int unsigned IMG_H = 64;
  localparam int unsigned PAD   = 1;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned CW    = 7;

  // Padded frame dimensions
  localparam int unsigned W2 = IMG_W + 2 * PAD;
  localparam int unsigned H2 = IMG_H + 2 * PAD;

  typedef logic [CW-1:0]    coord_t;
  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/pad_frame_writer_if.sv
// Control, pixel stream and buffer write port of the padded-frame writer.
interface pad_frame_writer_if;
  import img_pkg::*;

  logic   start;
  logic   abort;
  logic   s_valid;
  pixel_t s_pixel;
  logic   s_ready;
  logic   mem_we;
  coord_t mem_row;
  coord_t mem_col;
  pixel_t mem_wdata;
  logic   busy;
  logic   frame_done;

  modport slave (
    input  start, abort, s_valid, s_pixel,
    output s_ready, mem_we, mem_row, mem_col, mem_wdata, busy, frame_done
  );

  modport master (
    output start, abort, s_valid, s_pixel,
    input  s_ready, mem_we, mem_row, mem_col, mem_wdata, busy, frame_done
  );

endinterface

// File: rtl/pad_raster_cnt.sv
// Row/column raster counter over the padded frame; flags interior cells
// and the final cell of the frame.
module pad_raster_cnt
  import img_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_en,
  input  logic   i_clr,
  output coord_t o_row,
  output coord_t o_col,
  output logic   o_is_interior,
  output logic   o_is_last
);

  coord_t r_row;
  coord_t r_col;

  // Clear wins over advance; column wraps into the next row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_en) begin
      if (r_col == CW'(W2 - 1)) begin
        r_col <= '0;
        r_row <= (r_row == CW'(H2 - 1)) ? '0 : r_row + CW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign o_row         = r_row;
  assign o_col         = r_col;
  assign o_is_interior = (r_row >= CW'(PAD)) && (r_row < CW'(PAD + IMG_H)) &&
                         (r_col >= CW'(PAD)) && (r_col < CW'(PAD + IMG_W));
  assign o_is_last     = (r_row == CW'(H2 - 1)) && (r_col == CW'(W2 - 1));

endmodule

// File: rtl/pad_frame_writer.sv
// Writes a zero-padded frame into the window buffer: stream pixels into the
// interior, zeros into the border, one registered write per visited cell.
module pad_frame_writer
  import img_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  pad_frame_writer_if.slave bus
);

  state_t r_state;
  coord_t w_row;
  coord_t w_col;
  logic   w_interior;
  logic   w_last;
  logic   w_scan;
  logic   w_visit;
  logic   w_clr;

  assign w_scan  = (r_state == SCAN);
  // Border cells always advance; interior cells wait for a valid pixel
  assign w_visit = w_scan && !bus.abort && (!w_interior || bus.s_valid);
  assign w_clr   = bus.abort || ((r_state == IDLE) && bus.start);

  assign bus.s_ready = w_scan && w_interior;
  assign bus.busy    = w_scan;

  pad_raster_cnt u_cnt (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_en          (w_visit),
    .i_clr         (w_clr),
    .o_row         (w_row),
    .o_col         (w_col),
    .o_is_interior (w_interior),
    .o_is_last     (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      bus.mem_we     <= 1'b0;
      bus.mem_row    <= '0;
      bus.mem_col    <= '0;
      bus.mem_wdata  <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.mem_we     <= w_visit;
      bus.frame_done <= w_visit && w_last;
      if (w_visit) begin
        bus.mem_row   <= w_row;
        bus.mem_col   <= w_col;
        bus.mem_wdata <= w_interior ? bus.s_pixel : '0;
      end
      // abort outranks both start and end-of-frame
      if (bus.abort) begin
        r_state <= IDLE;
      end else if ((r_state == IDLE) && bus.start) begin
        r_state <= SCAN;
      end else if (w_visit && w_last) begin
        r_state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_pad_frame_writer.sv
// Self-checking bench for pad_frame_writer: flat-index frame model checked
// every cycle, plus hand-computed expectations on the captured buffer.
module tb_pad_frame_writer;
  import img_pkg::*;

  localparam int CELLS = H2 * W2;

  logic clk;
  logic rst_n;
  pad_frame_writer_if bus ();

  pad_frame_writer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: flat cell index of the frame being scanned
  bit     m_scan;
  int     m_p;
  bit     e_we, e_done;
  int     e_row, e_col, e_data;

  // Observed results
  logic [7:0] buf_mem [H2][W2];
  int wr_cnt, done_cnt, busy_cnt, border_zero;
  int pix_idx;
  bit pend_hs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_int(input int r, input int c);
    return (r >= int'(PAD)) && (r < int'(PAD + IMG_H)) &&
           (c >= int'(PAD)) && (c < int'(PAD + IMG_W));
  endfunction

  task automatic model_step();
    int r, c;
    bit inter;
    if (!rst_n) begin
      m_scan = 0; m_p = 0; e_we = 0; e_done = 0;
      e_row = 0; e_col = 0; e_data = 0;
    end
    r = m_p / int'(W2);
    c = m_p % int'(W2);
    inter = is_int(r, c);
    chk("mem_we",     32'(bus.mem_we),     32'(e_we));
    chk("mem_row",    32'(bus.mem_row),    32'(e_row));
    chk("mem_col",    32'(bus.mem_col),    32'(e_col));
    chk("mem_wdata",  32'(bus.mem_wdata),  32'(e_data));
    chk("frame_done", 32'(bus.frame_done), 32'(e_done));
    chk("busy",       32'(bus.busy),       32'(m_scan));
    chk("s_ready",    32'(bus.s_ready),    32'(m_scan && inter));
    if (bus.mem_we) begin
      wr_cnt++;
      if (int'(bus.mem_row) < int'(H2) && int'(bus.mem_col) < int'(W2)) begin
        buf_mem[bus.mem_row][bus.mem_col] = bus.mem_wdata;
        if (!is_int(int'(bus.mem_row), int'(bus.mem_col)) && bus.mem_wdata == 8'd0)
          border_zero++;
      end
    end
    if (bus.frame_done) done_cnt++;
    if (bus.busy) busy_cnt++;
    pend_hs = rst_n && bus.s_valid && bus.s_ready && !bus.abort;
    if (rst_n) begin
      e_we = 0; e_done = 0;
      if (m_scan) begin
        if (bus.abort) begin
          m_scan = 0; m_p = 0;
        end else if (!inter || bus.s_valid) begin
          e_we = 1; e_row = r; e_col = c;
          e_data = inter ? int'(bus.s_pixel) : 0;
          m_p++;
          if (m_p == CELLS) begin
            e_done = 1; m_scan = 0; m_p = 0;
          end
        end
      end else if (bus.start && !bus.abort) begin
        m_scan = 1; m_p = 0;
      end
    end
  endtask

  // One clock: check/update model at negedge, advance pixel source after posedge
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    if (pend_hs) pix_idx++;
    bus.s_pixel = 8'(pix_idx);
  endtask

  task automatic clear_obs();
    wr_cnt = 0; done_cnt = 0; busy_cnt = 0; border_zero = 0;
    for (int r = 0; r < int'(H2); r++)
      for (int c = 0; c < int'(W2); c++)
        buf_mem[r][c] = 8'hxx;
  endtask

  task automatic start_frame();
    pix_idx = 0;
    bus.s_pixel = 8'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_to_done(input string name);
    int n = 0;
    while (done_cnt == 0 && n < 6000) begin
      tick();
      n++;
    end
    chk(name, 32'(n < 6000), 32'd1);
    tick();
    tick();
  endtask

  task automatic advance_to_pixel(input int idx);
    int n = 0;
    while (pix_idx < idx && n < 6000) begin
      tick();
      n++;
    end
    chk("reach_pixel", 32'(pix_idx), 32'(idx));
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_writes"},  32'(wr_cnt),        32'd4356);
    chk({tag, "_done"},    32'(done_cnt),      32'd1);
    chk({tag, "_border0"}, 32'(border_zero),   32'd260);
    chk({tag, "_c0_0"},    32'(buf_mem[0][0]), 32'd0);
    chk({tag, "_c1_1"},    32'(buf_mem[1][1]), 32'd0);
    chk({tag, "_c1_2"},    32'(buf_mem[1][2]), 32'd1);
    chk({tag, "_c5_7"},    32'(buf_mem[5][7]), 32'd6);
    chk({tag, "_c5_1"},    32'(buf_mem[5][1]), 32'd0);
    chk({tag, "_c64_64"},  32'(buf_mem[64][64]), 32'd255);
    chk({tag, "_c65_65"},  32'(buf_mem[65][65]), 32'd0);
    chk({tag, "_c33_65"},  32'(buf_mem[33][65]), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.s_valid = 1'b0; bus.s_pixel = 8'd0;
    pix_idx = 0;
    clear_obs();
    repeat (3) tick();
    chk("rst_busy",   32'(bus.busy),    32'd0);
    chk("rst_ready",  32'(bus.s_ready), 32'd0);
    chk("rst_we",     32'(bus.mem_we),  32'd0);
    chk("rst_row",    32'(bus.mem_row), 32'd0);
    rst_n = 1'b1;
    tick();

    // Full frame, s_valid held high including across border rows
    bus.s_valid = 1'b1;
    clear_obs();
    start_frame();
    run_to_done("f1_timeout");
    check_frame("f1");
    chk("f1_busy_cycles", 32'(busy_cnt), 32'd4356);
    chk("f1_pixels",      32'(pix_idx),  32'd4096);

    // Stall at interior cell (5,7), then abort at (30,30)
    clear_obs();
    start_frame();
    advance_to_pixel(262);
    bus.s_valid = 1'b0;
    begin
      int we_seen = 0, rdy_seen = 0;
      tick();
      for (int i = 0; i < 10; i++) begin
        tick();
        if (bus.mem_we) we_seen++;
        if (bus.s_ready) rdy_seen++;
      end
      chk("stall_we",    32'(we_seen),  32'd0);
      chk("stall_ready", 32'(rdy_seen), 32'd10);
    end
    bus.s_valid = 1'b1;
    tick();
    chk("post_stall_we",  32'(bus.mem_we),    32'd1);
    chk("post_stall_row", 32'(bus.mem_row),   32'd5);
    chk("post_stall_col", 32'(bus.mem_col),   32'd7);
    chk("post_stall_dat", 32'(bus.mem_wdata), 32'd6);
    advance_to_pixel(1885);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy),   32'd0);
    chk("abort_we",   32'(bus.mem_we), 32'd0);
    repeat (5) tick();
    chk("abort_no_done", 32'(done_cnt), 32'd0);

    // start together with abort in IDLE is ignored
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    tick();
    chk("start_abort_idle", 32'(bus.busy), 32'd0);

    // Restart from (0,0); start pulse while busy is ignored
    start_frame();
    tick();
    chk("restart_we",  32'(bus.mem_we),  32'd1);
    chk("restart_row", 32'(bus.mem_row), 32'd0);
    chk("restart_col", 32'(bus.mem_col), 32'd0);
    repeat (100) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (50) tick();

    // Asynchronous reset mid-frame: outputs clear before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",  32'(bus.busy),       32'd0);
    chk("arst_ready", 32'(bus.s_ready),    32'd0);
    chk("arst_we",    32'(bus.mem_we),     32'd0);
    chk("arst_row",   32'(bus.mem_row),    32'd0);
    chk("arst_col",   32'(bus.mem_col),    32'd0);
    chk("arst_data",  32'(bus.mem_wdata),  32'd0);
    chk("arst_done",  32'(bus.frame_done), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    clear_obs();
    start_frame();
    run_to_done("f3_timeout");
    check_frame("f3");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
